// File: rtl/wbr_pkg.sv
// Shared types and constants for the s349 wrapper boundary register sequencer.
package wbr_pkg;

  localparam int unsigned WBR_CHAIN_LEN = 3;
  localparam int unsigned WBR_CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    UPDATE  = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    DONE    = 3'd5
  } wbr_seq_state_t;

endpackage

// File: rtl/wbr_bit_counter.sv
// Clearable bit counter shared by the LOAD and UNLOAD shift phases.
// tc_c flags the last bit position (CHAIN_LEN-1).
module wbr_bit_counter #(
  parameter int unsigned CHAIN_LEN = 3,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc_c
);

  // Counter register; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == CNT_W'(CHAIN_LEN - 1));

endmodule

// File: rtl/wbr_scan_seq.sv
// Sequencer for the WBR shift chain: load-shift, update, capture, unload-shift,
// then present the collected response with a one-cycle resp_valid.
// Optional response compare enabled by defining WBR_SCAN_SEQ_CMP_EN.
module wbr_scan_seq
  import wbr_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = WBR_CHAIN_LEN,
  parameter int unsigned CNT_W     = WBR_CNT_W
) (
  input  logic                 clk,
  input  logic                 WRSTN,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic                 abort,
  output logic                 ready,
  output logic                 wbr_si,
  input  logic                 wbr_so,
  output logic                 wbr_shift,
  output logic                 wbr_update,
  output logic                 wbr_capture,
  output logic [CHAIN_LEN-1:0] resp_out,
  output logic                 resp_valid
`ifdef WBR_SCAN_SEQ_CMP_EN
  ,
  input  logic [CHAIN_LEN-1:0] expected_in,
  output logic                 fail,
  output logic                 fail_sticky
`endif
);

  wbr_seq_state_t       state_q, state_d;
  logic [CHAIN_LEN-1:0] pattern_q, resp_q, pat_nxt, resp_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 tc_c, cnt_clr, cnt_inc, load_pat, sample, finish, si_nxt;

  wbr_bit_counter #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (WRSTN),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .tc_c  (tc_c)
  );

  // State register.
  always_ff @(posedge clk or negedge WRSTN) begin
    if (!WRSTN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter control and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    load_pat = 1'b0;
    sample   = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE:    if (start) begin
                 state_d  = LOAD;
                 load_pat = 1'b1;
               end
      LOAD:    if (tc_c) state_d = UPDATE;
               else      cnt_inc = 1'b1;
      UPDATE:  state_d = CAPTURE;
      CAPTURE: state_d = UNLOAD;
      UNLOAD:  begin
                 sample = 1'b1;
                 if (tc_c) begin
                   state_d = DONE;
                   finish  = 1'b1;
                 end else begin
                   cnt_inc = 1'b1;
                 end
               end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort beats every busy-state transition; in IDLE start is honoured.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      sample  = 1'b0;
      finish  = 1'b0;
    end
    // Every state entry restarts the bit count.
    if (state_d != state_q) begin
      cnt_clr = 1'b1;
      cnt_inc = 1'b0;
    end
    cnt_nxt = cnt_clr ? '0 : (cnt_inc ? cnt + CNT_W'(1) : cnt);
    pat_nxt = load_pat ? pattern_in : pattern_q;
    si_nxt   = 1'b0;
    resp_nxt = resp_q;
    for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
      if (cnt_nxt == CNT_W'(i)) si_nxt = pat_nxt[i];
      if (cnt == CNT_W'(i)) resp_nxt[i] = wbr_so;
    end
  end

  // Registered chain controls and data registers, decoded from the next state.
  always_ff @(posedge clk or negedge WRSTN) begin
    if (!WRSTN) begin
      ready       <= 1'b1;
      wbr_si      <= 1'b0;
      wbr_shift   <= 1'b0;
      wbr_update  <= 1'b0;
      wbr_capture <= 1'b0;
      resp_valid  <= 1'b0;
      pattern_q   <= '0;
      resp_q      <= '0;
      resp_out    <= '0;
    end else begin
      ready       <= (state_d == IDLE);
      wbr_shift   <= (state_d == LOAD) || (state_d == UNLOAD);
      wbr_update  <= (state_d == UPDATE);
      wbr_capture <= (state_d == CAPTURE);
      resp_valid  <= (state_d == DONE);
      wbr_si      <= (state_d == LOAD) ? si_nxt : 1'b0;
      pattern_q   <= pat_nxt;
      if (sample) resp_q <= resp_nxt;
      if (finish) resp_out <= resp_nxt;
    end
  end

`ifdef WBR_SCAN_SEQ_CMP_EN
  logic [CHAIN_LEN-1:0] expected_q;

  // Response compare: fail follows each finished run, fail_sticky only clears on reset.
  always_ff @(posedge clk or negedge WRSTN) begin
    if (!WRSTN) begin
      expected_q  <= '0;
      fail        <= 1'b0;
      fail_sticky <= 1'b0;
    end else begin
      if (load_pat) expected_q <= expected_in;
      if (finish) begin
        fail        <= (resp_nxt != expected_q);
        fail_sticky <= fail_sticky | (resp_nxt != expected_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_wbr_scan_seq.sv
// Bench for wbr_scan_seq: behavioural WBR chain with capture-fault injection,
// table vectors, hand sequences for back-to-back/abort/reset, random runs.
module tb_wbr_scan_seq;

  localparam int N   = 3;
  localparam int LAT = 2 * N + 3;

  logic         clk = 1'b0;
  logic         wrstn, start, abort, wbr_so;
  logic         ready, wbr_si, wbr_shift, wbr_update, wbr_capture, resp_valid;
  logic [N-1:0] pattern_in, resp_out;
`ifdef WBR_SCAN_SEQ_CMP_EN
  logic [N-1:0] expected_in;
  logic         fail, fail_sticky;
`endif

  int           n_vec = 0;
  int           n_bad = 0;
  logic [N-1:0] cells, fault_mask, last_resp;
  logic         sticky_m;

  typedef struct {
    logic [N-1:0] pat;
    logic [N-1:0] flt;
    logic [N-1:0] exp_in;
    logic [N-1:0] resp;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  wbr_scan_seq dut (
    .clk         (clk),
    .WRSTN       (wrstn),
    .start       (start),
    .pattern_in  (pattern_in),
    .abort       (abort),
    .ready       (ready),
    .wbr_si      (wbr_si),
    .wbr_so      (wbr_so),
    .wbr_shift   (wbr_shift),
    .wbr_update  (wbr_update),
    .wbr_capture (wbr_capture),
    .resp_out    (resp_out),
    .resp_valid  (resp_valid)
`ifdef WBR_SCAN_SEQ_CMP_EN
    ,
    .expected_in (expected_in),
    .fail        (fail),
    .fail_sticky (fail_sticky)
`endif
  );

  // Chain model: cell 0 nearest wbr_si; capture returns the loaded image with
  // response bit i flipped where fault_mask[i] is set.
  always @(posedge clk or negedge wrstn) begin
    if (!wrstn) begin
      cells <= '0;
    end else if (wbr_shift) begin
      cells <= {cells[N-2:0], wbr_si};
    end else if (wbr_capture) begin
      for (int i = 0; i < N; i++) cells[N-1-i] <= cells[N-1-i] ^ fault_mask[i];
    end
  end
  assign wbr_so = cells[N-1];

  function automatic logic [5:0] obs();
    return {ready, wbr_shift, wbr_update, wbr_capture, resp_valid, wbr_si};
  endfunction

  // Expected {ready,shift,update,capture,valid,si} in cycle r after an accept.
  function automatic logic [5:0] exp_word(input logic [N-1:0] p, input int r);
    logic [N-1:0] t;
    if (r >= 1 && r <= N) begin
      t = p >> (r - 1);
      return {5'b01000, t[0]};
    end
    if (r == N + 1) return 6'b001000;
    if (r == N + 2) return 6'b000100;
    if (r >= N + 3 && r <= 2 * N + 2) return 6'b010000;
    if (r == 2 * N + 3) return 6'b000010;
    return 6'b100000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] pat, input logic [N-1:0] expin);
    pattern_in = pat;
`ifdef WBR_SCAN_SEQ_CMP_EN
    expected_in = expin;
`else
    if (expin == '1) pattern_in = pat;
`endif
  endtask

  // One full pattern run with cycle-by-cycle output checks.
  task automatic run_pattern(input logic [N-1:0] pat, input logic [N-1:0] flt,
                             input logic [N-1:0] exp_in, input logic [N-1:0] exp_resp,
                             input string nm);
    fault_mask = flt;
    @(negedge clk);
    chk({nm, " idle"}, 32'(obs()), 32'(exp_word(pat, 0)));
    start = 1'b1;
    drive(pat, exp_in);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        drive(N'($urandom), N'($urandom));
      end
      chk($sformatf("%s c%0d", nm, k), 32'(obs()), 32'(exp_word(pat, k)));
      if (k == LAT) begin
        chk({nm, " resp"}, 32'(resp_out), 32'(exp_resp));
`ifdef WBR_SCAN_SEQ_CMP_EN
        sticky_m = sticky_m | (exp_resp != exp_in);
        chk({nm, " fail"}, 32'(fail), 32'(exp_resp != exp_in));
        chk({nm, " sticky"}, 32'(fail_sticky), 32'(sticky_m));
`endif
      end
    end
    last_resp = exp_resp;
  endtask

  initial begin
    logic [N-1:0] p, f, pp;
    int r;
    tbl[0] = '{3'b101, 3'b000, 3'b101, 3'b101};
    tbl[1] = '{3'b010, 3'b000, 3'b010, 3'b010};
    tbl[2] = '{3'b111, 3'b000, 3'b111, 3'b111};
    tbl[3] = '{3'b000, 3'b000, 3'b000, 3'b000};
    tbl[4] = '{3'b110, 3'b001, 3'b111, 3'b111};
    tbl[5] = '{3'b011, 3'b100, 3'b111, 3'b111};

    wrstn = 1'b0; start = 1'b0; abort = 1'b0; fault_mask = '0;
    drive('0, '0);
    sticky_m = 1'b0; last_resp = '0;
    #20 wrstn = 1'b1;

    // Reset state and idle without start.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset word", 32'(obs()), 32'(6'b100000));
      chk("reset resp", 32'(resp_out), 32'(0));
    end

    // Table vectors.
    for (int i = 0; i < 6; i++)
      run_pattern(tbl[i].pat, tbl[i].flt, tbl[i].exp_in, tbl[i].resp, $sformatf("tbl%0d", i));

    // Back-to-back with start held: second accept 10 cycles after the first.
    fault_mask = '0;
    @(negedge clk);
    start = 1'b1;
    drive(3'b111, 3'b111);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) drive(3'b100, 3'b100);
      r  = (k <= 10) ? k : k - 10;
      pp = (k < 10) ? 3'b111 : 3'b100;
      chk($sformatf("b2b c%0d", k), 32'(obs()), 32'(exp_word(pp, r)));
      if (k == 9)  chk("b2b resp1", 32'(resp_out), 32'(3'b111));
      if (k == 19) chk("b2b resp2", 32'(resp_out), 32'(3'b100));
      if (k == 18) start = 1'b0;
    end
    last_resp = 3'b100;

    // Start and abort together in IDLE: start wins; then abort during LOAD.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    drive(3'b110, 3'b110);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; abort = 1'b0; end
      if (k == 3) abort = 1'b0;
      chk($sformatf("stab c%0d", k), 32'(obs()), 32'((k <= 2) ? exp_word(3'b110, k) : 6'b100000));
      if (k == 2) abort = 1'b1;
    end
    chk("stab resp", 32'(resp_out), 32'(last_resp));

    // Abort in the second UNLOAD cycle.
    @(negedge clk);
    start = 1'b1;
    drive(3'b010, 3'b010);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 8) abort = 1'b0;
      chk($sformatf("abort c%0d", k), 32'(obs()), 32'((k <= 7) ? exp_word(3'b010, k) : 6'b100000));
      if (k >= 8) chk($sformatf("abort resp c%0d", k), 32'(resp_out), 32'(last_resp));
      if (k == 7) abort = 1'b1;
    end

    // Async reset in the middle of LOAD.
    @(negedge clk);
    start = 1'b1;
    drive(3'b101, 3'b101);
    @(negedge clk);
    start = 1'b0;
    chk("rst pre", 32'(obs()), 32'(exp_word(3'b101, 1)));
    @(posedge clk);
    #2 wrstn = 1'b0;
    #1;
    chk("rst shift", 32'(wbr_shift), 32'(0));
    chk("rst word", 32'(obs()), 32'(6'b100000));
    chk("rst resp", 32'(resp_out), 32'(0));
    @(negedge clk);
    wrstn = 1'b1;
    last_resp = '0;
    sticky_m = 1'b0;
    @(negedge clk);
    chk("rst post", 32'(obs()), 32'(6'b100000));

    // Random runs against the chain-image model.
    for (int i = 0; i < 10; i++) begin
      p = N'($urandom_range(0, 7));
      f = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 7)) : '0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_pattern(p, f, p ^ f, p ^ f, $sformatf("rnd%0d", i));
    end

`ifdef WBR_SCAN_SEQ_CMP_EN
    // Compare: pass, faulted fail, then pass with sticky still set.
    run_pattern(3'b001, 3'b000, 3'b001, 3'b001, "cmp pass");
    run_pattern(3'b001, 3'b010, 3'b001, 3'b011, "cmp fault");
    run_pattern(3'b010, 3'b000, 3'b010, 3'b010, "cmp after");
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
